// File: rtl/dm_scroll_feeder.sv
// dm_scroll_feeder
//   Frame source for the 8x8 dot-matrix scan driver. Glyphs are queued in a
//   small FIFO and scrolled leftward through the displayed frame one column
//   per step. Steps only happen on the scan driver's end-of-frame pulse, so a
//   displayed frame never tears.
// Ports
//   i_Clk    system clock
//   i_Rst    asynchronous active-high reset
//   i_fDone  end-of-frame pulse from the scan driver (1 cycle)
//   i_Clear  synchronous flush of FIFO, active glyph and frame
//   i_Valid  i_Glyph valid
//   i_Glyph  64-bit glyph; byte k = row k, bit 7 = leftmost column
//   o_Ready  FIFO can accept a glyph (not full)
//   o_Data   displayed frame, same layout as i_Glyph
//   o_Idle   FIFO empty and no glyph active
module dm_scroll_feeder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STEP_FRMS = 8,
  parameter bit          BLANK     = 1'b1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_fDone,
  input  logic        i_Clear,
  input  logic        i_Valid,
  input  logic [63:0] i_Glyph,
  output logic        o_Ready,
  output logic [63:0] o_Data,
  output logic        o_Idle
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW = (STEP_FRMS > 1) ? $clog2(STEP_FRMS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_FRMS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SCROLL = 2'd2;

  logic [63:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;

  logic [1:0]    state;
  logic [63:0]   c_next;
  logic [2:0]    c_col;
  logic [DW-1:0] c_div;

  logic          busy;
  logic          step;
  logic          last_col_step;
  logic          push;
  logic          pop;
  logic [63:0]   shifted;
  logic          in_bit;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign busy          = (state == ST_SCROLL);
  assign step          = i_fDone && (c_div == DIV_LAST);
  assign last_col_step = busy && step && (c_col == 3'd7);

  // Full blocks a push even when a pop frees a slot on the same edge.
  assign push = i_Valid && !fifo_full && !i_Clear;
  // Pop either to start scrolling from rest, or to chain the next glyph
  // directly after the last column of the current one (gapless join).
  assign pop  = !fifo_empty && !i_Clear && (!busy || last_col_step);

  assign o_Ready = !fifo_full;
  assign o_Idle  = fifo_empty && !busy;

  // Next frame: every row shifts left by one; the incoming bit is the
  // current column of the active glyph (bit 7-c_col == ~c_col of the row).
  always_comb begin
    shifted = '0;
    in_bit  = BLANK;
    for (int unsigned k = 0; k < 8; k++) begin
      in_bit = busy ? c_next[{3'(k), ~c_col}] : BLANK;
      shifted[8*k +: 8] = {o_Data[8*k +: 7], in_bit};
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= i_Glyph;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= ST_IDLE;
      c_next <= '0;
      c_col  <= '0;
      c_div  <= '0;
      o_Data <= {64{BLANK}};
    end else if (i_Clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= ST_IDLE;
      c_col  <= '0;
      c_div  <= '0;
      o_Data <= {64{BLANK}};
    end else begin
      if (i_fDone) begin
        c_div <= (c_div == DIV_LAST) ? '0 : c_div + 1'b1;
      end

      if (step) begin
        o_Data <= shifted;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        c_next <= mem[rd_ptr[AW-1:0]];
        c_col  <= '0;
      end else if (busy && step) begin
        c_col <= c_col + 1'b1;
      end

      // LOAD mirrors "not busy with data queued"; a push landing on the
      // final-column edge of an empty FIFO must route SCROLL straight to LOAD.
      case (state)
        ST_IDLE: begin
          if (push) state <= ST_LOAD;
        end
        ST_LOAD: begin
          state <= ST_SCROLL;
        end
        ST_SCROLL: begin
          if (last_col_step && fifo_empty) begin
            state <= push ? ST_LOAD : ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_scroll_feeder.sv
// Self-checking bench for dm_scroll_feeder: directed scenarios plus
// randomized traffic compared cycle by cycle against a behavioural model
// built from a glyph queue and an array of frame rows.
module tb_dm_scroll_feeder;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned STEP_FRMS = 3;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        i_fDone;
  logic        i_Clear;
  logic        i_Valid;
  logic [63:0] i_Glyph;
  logic        o_Ready;
  logic [63:0] o_Data;
  logic        o_Idle;

  dm_scroll_feeder #(
    .DEPTH(DEPTH),
    .STEP_FRMS(STEP_FRMS),
    .BLANK(1'b1)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_fDone(i_fDone),
    .i_Clear(i_Clear),
    .i_Valid(i_Valid),
    .i_Glyph(i_Glyph),
    .o_Ready(o_Ready),
    .o_Data(o_Data),
    .o_Idle(o_Idle)
  );

  always #5 i_Clk = ~i_Clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: queued glyphs, active glyph with its next column,
  // frame-pulse counter, and the eight displayed rows.
  logic [63:0] m_q[$];
  logic [63:0] m_cur;
  int          m_col;
  bit          m_busy;
  int          m_div;
  logic [7:0]  m_row [8];

  function automatic logic [63:0] m_frame();
    logic [63:0] f;
    for (int k = 0; k < 8; k++) f[8*k +: 8] = m_row[k];
    return f;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy = 1'b0;
    m_col  = 0;
    m_div  = 0;
    for (int k = 0; k < 8; k++) m_row[k] = 8'hFF;
  endtask

  // Evaluated once per rising edge with the inputs that were stable before it.
  task automatic model_edge();
    bit push, step, had;
    if (i_Rst || i_Clear) begin
      model_reset();
      return;
    end
    push = i_Valid && (m_q.size() < DEPTH);
    step = i_fDone && (m_div == STEP_FRMS - 1);
    had  = (m_q.size() != 0);
    if (i_fDone) m_div = step ? 0 : m_div + 1;
    if (step) begin
      for (int k = 0; k < 8; k++)
        m_row[k] = {m_row[k][6:0], m_busy ? m_cur[8*k + 7 - m_col] : 1'b1};
    end
    if (!m_busy && had) begin
      m_cur  = m_q.pop_front();
      m_col  = 0;
      m_busy = 1'b1;
    end else if (m_busy && step) begin
      if (m_col == 7) begin
        if (had) begin
          m_cur = m_q.pop_front();
          m_col = 0;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_col++;
      end
    end
    if (push) m_q.push_back(i_Glyph);
  endtask

  task automatic compare_outputs();
    check("data",  o_Data,  m_frame());
    check("ready", 64'(o_Ready), 64'(m_q.size() < DEPTH));
    check("idle",  64'(o_Idle),  64'(m_q.size() == 0 && !m_busy));
  endtask

  task automatic tick();
    @(posedge i_Clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic push_glyph(input logic [63:0] g);
    i_Valid = 1'b1;
    i_Glyph = g;
    tick();
    i_Valid = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      i_fDone = 1'b1;
      tick();
      i_fDone = 1'b0;
      tick();
    end
  endtask

  // Called right after tick(): asserts reset between edges and checks the
  // asynchronous response before any clock edge occurs.
  task automatic async_reset();
    #2;
    i_Rst = 1'b1;
    #1;
    model_reset();
    check("rst_data",  o_Data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_idle",  64'(o_Idle), 64'd1);
    check("rst_ready", 64'(o_Ready), 64'd1);
    @(negedge i_Clk);
    i_Rst = 1'b0;
  endtask

  initial begin
    i_Rst   = 1'b1;
    i_fDone = 1'b0;
    i_Clear = 1'b0;
    i_Valid = 1'b0;
    i_Glyph = '0;
    model_reset();
    #3;
    check("reset_data",  o_Data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("reset_idle",  64'(o_Idle), 64'd1);
    check("reset_ready", 64'(o_Ready), 64'd1);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    tick();

    // Single glyph scrolls fully in after 8 steps and fully out after 8 more.
    push_glyph(64'h00FF_00FF_00FF_00FF);
    pulses(8 * STEP_FRMS);
    check("t1_full", o_Data, 64'h00FF_00FF_00FF_00FF);
    pulses(8 * STEP_FRMS);
    check("t1_gone", o_Data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t1_idle", 64'(o_Idle), 64'd1);

    // Backpressure: four pushes, one loads; fifth fills, sixth is dropped.
    push_glyph(64'h0102_0304_0506_0708);
    push_glyph(64'h1112_1314_1516_1718);
    push_glyph(64'h2122_2324_2526_2728);
    push_glyph(64'h3132_3334_3536_3738);
    check("t2_ready4", 64'(o_Ready), 64'd1);
    push_glyph(64'h4142_4344_4546_4748);
    check("t2_full", 64'(o_Ready), 64'd0);
    push_glyph(64'hDEAD_BEEF_DEAD_BEEF);
    pulses(40 * STEP_FRMS);
    check("t2_last", o_Data, 64'h4142_4344_4546_4748);
    pulses(8 * STEP_FRMS);
    check("t2_idle", 64'(o_Idle), 64'd1);

    // Divider: STEP_FRMS-1 pulses leave the frame alone, the next shifts.
    push_glyph(64'h0);
    tick();
    pulses(STEP_FRMS - 1);
    check("t3_hold", o_Data, 64'hFFFF_FFFF_FFFF_FFFF);
    pulses(1);
    check("t3_shift", o_Data, 64'hFEFE_FEFE_FEFE_FEFE);

    // Clear with a concurrent push and frame pulse mid-scroll.
    pulses(2 * STEP_FRMS);
    i_Clear = 1'b1;
    i_Valid = 1'b1;
    i_fDone = 1'b1;
    i_Glyph = 64'h0;
    tick();
    i_Clear = 1'b0;
    i_Valid = 1'b0;
    i_fDone = 1'b0;
    check("t5_data",  o_Data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t5_idle",  64'(o_Idle), 64'd1);
    check("t5_ready", 64'(o_Ready), 64'd1);
    pulses(4 * STEP_FRMS);
    check("t5_absent", o_Data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Asynchronous reset mid-scroll with two glyphs queued.
    push_glyph(64'h0);
    push_glyph(64'h1234_5678_9ABC_DEF0);
    push_glyph(64'h0F0F_0F0F_0F0F_0F0F);
    pulses(3 * STEP_FRMS);
    async_reset();
    pulses(10 * STEP_FRMS);
    check("t6_absent", o_Data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Randomized traffic: heavy then light push rates, sparse clears/resets.
    for (int i = 0; i < 4000; i++) begin
      i_Valid = ($urandom_range(0, (i < 2000) ? 3 : 80) == 0);
      i_Glyph = {$urandom, $urandom};
      i_fDone = !i_fDone && ($urandom_range(0, 1) == 0);
      i_Clear = ($urandom_range(0, 299) == 0);
      tick();
      if ($urandom_range(0, 499) == 0) async_reset();
    end
    i_Valid = 1'b0;
    i_Clear = 1'b0;
    i_fDone = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
